// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU control path: opcodes, ALU ops, mux encodings, FSM states.
// MULTICYCLE_CTRL_TRAP_EN adds the HALT state used to trap illegal opcodes.
package cpu_pkg;

    localparam logic [5:0] OP_NOP = 6'd0;
    localparam logic [5:0] OP_ADD = 6'd1;
    localparam logic [5:0] OP_SUB = 6'd2;
    localparam logic [5:0] OP_AND = 6'd3;
    localparam logic [5:0] OP_OR  = 6'd4;
    localparam logic [5:0] OP_SLT = 6'd5;
    localparam logic [5:0] OP_LW  = 6'd6;
    localparam logic [5:0] OP_SW  = 6'd7;
    localparam logic [5:0] OP_JMP = 6'd8;
    localparam logic [5:0] OP_BEQ = 6'd9;
    localparam logic [5:0] OP_BNE = 6'd10;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_LT  = 3'd4;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [1:0] SRC_B_REG = 2'd0;
    localparam logic [1:0] SRC_B_ONE = 2'd1;
    localparam logic [1:0] SRC_B_IMM = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC_R = 4'd3,
        ST_WB_R   = 4'd4,
        ST_ADDR   = 4'd5,
        ST_MEM_RD = 4'd6,
        ST_WB_MEM = 4'd7,
        ST_MEM_WR = 4'd8,
        ST_BRANCH = 4'd9,
        ST_JUMP   = 4'd10
`ifdef MULTICYCLE_CTRL_TRAP_EN
        , ST_HALT = 4'd11
`endif
    } mc_state_t;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic [2:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       retire;
        logic       illegal;
    } mc_ctrl_t;

    function automatic logic opcode_is_legal(input logic [5:0] op);
        return (op <= OP_BNE);
    endfunction

    function automatic logic [2:0] r_type_alu_op(input logic [5:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_SLT:  return ALU_LT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational output map of the multi-cycle controller: (state, opcode, zero, mem_ready) -> control bundle.
// MULTICYCLE_CTRL_TRAP_EN: illegal opcodes do not retire in DECODE and HALT raises illegal.
module multicycle_ctrl_decode
    import cpu_pkg::*;
(
    input  mc_state_t  state,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output mc_ctrl_t   ctrl
);

    // Per-state control outputs; everything not named in a state stays 0
    always_comb begin
        ctrl = '0;
        case (state)
            ST_IDLE: begin
                ctrl = '0;
            end
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRC_B_ONE;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = PC_SRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                // ALUOut <= PC + imm so BRANCH can use it as the target
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_ADD;
`ifdef MULTICYCLE_CTRL_TRAP_EN
                ctrl.retire    = (opcode == OP_NOP);
`else
                ctrl.retire    = (opcode == OP_NOP) || !opcode_is_legal(opcode);
`endif
            end
            ST_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_REG;
                ctrl.alu_op    = r_type_alu_op(opcode);
            end
            ST_WB_R: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.retire     = 1'b1;
            end
            ST_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            ST_WB_MEM: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b1;
                ctrl.retire     = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
                ctrl.retire    = mem_ready;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_REG;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_src    = PC_SRC_ALUOUT;
                ctrl.retire    = 1'b1;
                ctrl.pc_write  = (opcode == OP_BNE) ? !zero : zero;
            end
            ST_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PC_SRC_JUMP;
                ctrl.retire   = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_TRAP_EN
            ST_HALT: begin
                ctrl.illegal = 1'b1;
            end
`endif
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU sequencing controller: state register, next-state logic and memory wait counter.
// Define MULTICYCLE_CTRL_TRAP_EN to send illegal opcodes to a sticky HALT state instead of treating them as NOP.
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic [2:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       retire,
    output logic       illegal,
    output logic       mem_timeout
);

    localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT_MAX);

    mc_state_t  state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       waiting_s;
    mc_ctrl_t   ctrl_s;

    multicycle_ctrl_decode u_decode (
        .state     (state_q),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_s)
    );

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH:  state_d = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if (opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT}) begin
                    state_d = ST_EXEC_R;
                end else if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = ST_ADDR;
                end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
                    state_d = ST_BRANCH;
                end else if (opcode == OP_JMP) begin
                    state_d = ST_JUMP;
`ifdef MULTICYCLE_CTRL_TRAP_EN
                end else if (!opcode_is_legal(opcode)) begin
                    state_d = ST_HALT;
`endif
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC_R: state_d = ST_WB_R;
            ST_WB_R:   state_d = ST_FETCH;
            ST_ADDR:   state_d = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: state_d = mem_ready ? ST_WB_MEM : ST_MEM_RD;
            ST_WB_MEM: state_d = ST_FETCH;
            ST_MEM_WR: state_d = mem_ready ? ST_FETCH : ST_MEM_WR;
            ST_BRANCH: state_d = ST_FETCH;
            ST_JUMP:   state_d = ST_FETCH;
`ifdef MULTICYCLE_CTRL_TRAP_EN
            ST_HALT:   state_d = ST_HALT;
`endif
            default:   state_d = ST_IDLE;
        endcase
    end

    // Saturating wait counter; any cycle that is not a stalled memory phase leaves it at 0,
    // which also clears it on entry to FETCH, MEM_RD and MEM_WR
    always_comb begin
        waiting_s = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);
        if (waiting_s && !mem_ready) begin
            wait_cnt_d = (wait_cnt_q >= WAIT_MAX) ? WAIT_MAX : wait_cnt_q + 4'd1;
        end else begin
            wait_cnt_d = 4'd0;
        end
    end

    // State and wait-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign pc_write    = ctrl_s.pc_write;
    assign pc_src      = ctrl_s.pc_src;
    assign ir_write    = ctrl_s.ir_write;
    assign iord        = ctrl_s.iord;
    assign mem_read    = ctrl_s.mem_read;
    assign mem_write   = ctrl_s.mem_write;
    assign alu_op      = ctrl_s.alu_op;
    assign alu_src_a   = ctrl_s.alu_src_a;
    assign alu_src_b   = ctrl_s.alu_src_b;
    assign reg_dst     = ctrl_s.reg_dst;
    assign mem_to_reg  = ctrl_s.mem_to_reg;
    assign reg_write   = ctrl_s.reg_write;
    assign retire      = ctrl_s.retire;
    assign illegal     = ctrl_s.illegal;
    assign mem_timeout = (wait_cnt_q == WAIT_MAX);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes expected latency/retire-cycle outputs,
// a monitor pops and checks them on every retire pulse; phase-level checks are made inline.
module tb_multicycle_ctrl;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_write, ir_write, iord, mem_read, mem_write, alu_src_a;
    logic       reg_dst, mem_to_reg, reg_write, retire, illegal, mem_timeout;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] alu_op;

    multicycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .alu_op(alu_op),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .retire(retire),
        .illegal(illegal), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         lat;
        logic [9:0] snap;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // {ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg, mem_read, mem_write, iord}
    function automatic logic [9:0] snap_now();
        return {ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg, mem_read, mem_write, iord};
    endfunction

    function automatic logic [18:0] all_out();
        return {pc_write, pc_src, ir_write, iord, mem_read, mem_write, alu_op, alu_src_a,
                alu_src_b, reg_dst, mem_to_reg, reg_write, retire, illegal, mem_timeout};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: measures latency from first FETCH cycle and checks each retire against the queue
    initial begin : monitor
        bit   in_instr;
        int   mon_lat;
        exp_t e;
        in_instr = 1'b0;
        mon_lat  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_instr = 1'b0;
                mon_lat  = 0;
            end else begin
                if (!in_instr && mem_read && !iord) begin
                    in_instr = 1'b1;
                    mon_lat  = 0;
                end
                if (in_instr) mon_lat++;
                if (retire) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_retire", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("latency", mon_lat, e.lat);
                        check("retire_outputs", {22'd0, snap_now()}, {22'd0, e.snap});
                    end
                    in_instr = 1'b0;
                end
            end
        end
    end

    // Asynchronous reset from any point; ends 1 time unit into the first FETCH cycle
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("reset_outputs_zero", {13'd0, all_out()}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("in_reset_outputs_zero", {13'd0, all_out()}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("idle_outputs_zero", {13'd0, all_out()}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction starting in its first FETCH cycle; returns in the next FETCH cycle.
    // fw/mw: cycles mem_ready is held low in FETCH / in the memory phase.
    task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw,
                             input int exp_lat, input logic [9:0] exp_snap, input logic [2:0] exp_aop);
        exp_t e;
        int   base;
        opcode = op;
        zero   = z;
        e.lat  = exp_lat;
        e.snap = exp_snap;
        exp_q.push_back(e);
        base = exp_lat - fw - mw;
        for (int i = 1; i <= fw; i++) begin
            mem_ready = 1'b0;
            @(negedge clk);
            check("fetch_hold", {30'd0, mem_read, iord}, 32'd2);
            check("mem_timeout", {31'd0, mem_timeout}, (i >= 16) ? 32'd1 : 32'd0);
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("decode_alu_src_b", {30'd0, alu_src_b}, {30'd0, SRC_B_IMM});
        @(posedge clk);
        #1;
        if (op == OP_LW || op == OP_SW) begin
            @(posedge clk);
            #1;
            for (int i = 0; i <= mw; i++) begin
                mem_ready = (i == mw);
                @(negedge clk);
                check("mem_phase_strobes", {29'd0, mem_read, mem_write, iord},
                      (op == OP_LW) ? 32'd5 : 32'd3);
                @(posedge clk);
                #1;
            end
            mem_ready = 1'b1;
            if (op == OP_LW) begin
                @(posedge clk);
                #1;
            end
        end else begin
            for (int j = 2; j < base; j++) begin
                if (j == 2) begin
                    @(negedge clk);
                    check("alu_op", {29'd0, alu_op}, {29'd0, exp_aop});
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin : stimulus
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        apply_reset();

        // op, zero, fetch-wait, mem-wait, latency, retire-cycle snapshot, exec alu_op
        run_instr(OP_ADD, 1'b0, 0, 0, 4, 10'b0_0_00_1_1_0_0_0_0, ALU_ADD);
        run_instr(OP_SUB, 1'b0, 0, 0, 4, 10'b0_0_00_1_1_0_0_0_0, ALU_SUB);
        run_instr(OP_AND, 1'b0, 2, 0, 6, 10'b0_0_00_1_1_0_0_0_0, ALU_AND);
        run_instr(OP_OR,  1'b0, 0, 0, 4, 10'b0_0_00_1_1_0_0_0_0, ALU_OR);
        run_instr(OP_SLT, 1'b0, 0, 0, 4, 10'b0_0_00_1_1_0_0_0_0, ALU_LT);
        run_instr(OP_LW,  1'b0, 0, 3, 8, 10'b0_0_00_1_0_1_0_0_0, ALU_ADD);
        run_instr(OP_SW,  1'b0, 0, 2, 6, 10'b0_0_00_0_0_0_0_1_1, ALU_ADD);
        run_instr(OP_BEQ, 1'b1, 0, 0, 3, 10'b0_1_01_0_0_0_0_0_0, ALU_SUB);
        run_instr(OP_BEQ, 1'b0, 0, 0, 3, 10'b0_0_01_0_0_0_0_0_0, ALU_SUB);
        run_instr(OP_BNE, 1'b1, 0, 0, 3, 10'b0_0_01_0_0_0_0_0_0, ALU_SUB);
        run_instr(OP_BNE, 1'b0, 0, 0, 3, 10'b0_1_01_0_0_0_0_0_0, ALU_SUB);
        run_instr(OP_JMP, 1'b0, 0, 0, 3, 10'b0_1_10_0_0_0_0_0_0, ALU_ADD);
        run_instr(OP_NOP, 1'b0, 0, 0, 2, 10'b0_0_00_0_0_0_0_0_0, ALU_ADD);
        // Long FETCH stall: timeout from the 16th waiting cycle, FSM keeps waiting
        run_instr(OP_NOP, 1'b0, 20, 0, 22, 10'b0_0_00_0_0_0_0_0_0, ALU_ADD);

`ifdef MULTICYCLE_CTRL_TRAP_EN
        opcode    = 6'h3F;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("illegal_decode_no_retire", {31'd0, retire}, 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            mem_ready = i[0];
            @(negedge clk);
            check("halt_outputs", {13'd0, all_out()}, 32'd2);
        end
        apply_reset();
`else
        run_instr(6'h3F, 1'b0, 0, 0, 2, 10'b0_0_00_0_0_0_0_0_0, ALU_ADD);
`endif

        // Reset during a stalled MEM_WR: strobe drops at once, nothing retires
        opcode    = OP_SW;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        @(negedge clk);
        check("mem_wr_before_reset", {29'd0, mem_read, mem_write, iord}, 32'd3);
        #2;
        apply_reset();
        mem_ready = 1'b1;
        run_instr(OP_ADD, 1'b0, 0, 0, 4, 10'b0_0_00_1_1_0_0_0_0, ALU_ADD);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Sequencing controller for the multi-cycle variant of the CPU datapath: a Moore/Mealy FSM that steps each instruction through fetch, decode, execute, memory and write-back, sharing one ALU and one unified memory port across those phases. It consumes the same opcode map and ALU operation codes as the single-cycle control decoder. It drives every datapath mux select and enable, and handshakes with memory through `mem_ready`.

## Interface
- `MEM_WAIT_MAX`, default 15: maximum cycles to wait on `mem_ready` before `mem_timeout` asserts (FSM keeps waiting).
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26]; stable from the DECODE cycle until the instruction retires.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current read/write this cycle.
- `pc_write` out 1: PC register load enable.
- `pc_src` out 2: 0 = ALU result (PC+1), 1 = ALUOut (branch target), 2 = jump target.
- `ir_write` out 1: instruction register load enable.
- `iord` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write` out 1 each: memory strobes, held until `mem_ready`.
- `alu_op` out 3: add=0, sub=1, and=2, or=3, lt=4.
- `alu_src_a` out 1: 0 = PC, 1 = register A.
- `alu_src_b` out 2: 0 = register B, 1 = constant 1, 2 = sign-extended immediate.
- `reg_dst` out 1: 1 = rd, 0 = rt.
- `mem_to_reg` out 1: 1 = MDR, 0 = ALUOut.
- `reg_write` out 1: register file write enable.
- `retire` out 1: one-cycle pulse on the final cycle of every instruction.
- `illegal` out 1: level; high while in HALT.
- `mem_timeout` out 1: level; high while the wait counter equals `MEM_WAIT_MAX`.

## Operation
- Opcodes: NOP=0, ADD=1, SUB=2, AND=3, OR=4, SLT=5, LW=6, SW=7, JMP=8, BEQ=9, BNE=10. All others are illegal.
- States: IDLE, FETCH, DECODE, EXEC_R, WB_R, ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, JUMP, HALT.
- Unlisted outputs are 0 in every state.
- IDLE:
  - All outputs 0.
  - Goes to FETCH unconditionally.
- FETCH:
  - Drives `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=add, `pc_src`=0.
  - `ir_write` and `pc_write` equal `mem_ready` (Mealy).
  - Stays in FETCH until `mem_ready`, then goes to DECODE.
- DECODE:
  - Drives `alu_src_a`=0, `alu_src_b`=2, `alu_op`=add, which precomputes the branch target into ALUOut.
  - Next state:
    - ADD..SLT: EXEC_R.
    - LW or SW: ADDR.
    - BEQ or BNE: BRANCH.
    - JMP: JUMP.
    - NOP: FETCH, with `retire`=1.
    - Illegal opcode: see Configuration.
- EXEC_R:
  - Drives `alu_src_a`=1, `alu_src_b`=0, `alu_op` per opcode.
  - Goes to WB_R.
- WB_R:
  - Drives `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, `retire`=1.
  - Goes to FETCH.
- ADDR:
  - Drives `alu_src_a`=1, `alu_src_b`=2, `alu_op`=add.
  - Goes to MEM_RD for LW, MEM_WR for SW.
- MEM_RD:
  - Drives `mem_read`=1, `iord`=1.
  - Waits for `mem_ready`, then goes to WB_MEM.
- WB_MEM:
  - Drives `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1, `retire`=1.
  - Goes to FETCH.
- MEM_WR:
  - Drives `mem_write`=1, `iord`=1.
  - On `mem_ready`: `retire`=1, goes to FETCH.
- BRANCH:
  - Drives `alu_src_a`=1, `alu_src_b`=0, `alu_op`=sub, `pc_src`=1, `retire`=1.
  - `pc_write` = `zero` for BEQ and `!zero` for BNE (Mealy).
  - Goes to FETCH.
- JUMP:
  - Drives `pc_write`=1, `pc_src`=2, `retire`=1.
  - Goes to FETCH.
- Wait counter:
  - 4 bits wide; cleared on entry to FETCH, MEM_RD and MEM_WR.
  - Increments each cycle those states hold without `mem_ready`.
  - Saturates at `MEM_WAIT_MAX`.

## Timing
- Reset:
  - `rst_n` low forces state IDLE asynchronously.
  - Every output and the wait counter are 0 while in reset.
  - Reset mid-instruction abandons the instruction; there is no partial write-back.
  - First FETCH occurs on the cycle after the first clock edge with `rst_n` high.
- Latency in cycles with zero memory wait:
  - NOP 2.
  - BEQ, BNE, JMP 3.
  - R-type 4.
  - SW 4.
  - LW 5.
- Each cycle `mem_ready` is low in FETCH, MEM_RD or MEM_WR adds one cycle.
- Memory handshake:
  - `mem_read`/`mem_write` stay asserted and `iord` stays stable until the cycle `mem_ready` is sampled high.
  - `mem_ready` outside FETCH, MEM_RD and MEM_WR is ignored.
  - `mem_read` and `mem_write` are never both 1.
- `retire`:
  - Exactly one pulse per instruction.
  - Never high in IDLE, FETCH or HALT.

## Configuration
- `MULTICYCLE_CTRL_TRAP_EN` defined:
  - An illegal opcode in DECODE goes to HALT.
  - HALT holds all outputs 0 except `illegal`=1.
  - Only reset exits HALT.
- Not defined:
  - An illegal opcode is treated as NOP: DECODE goes to FETCH with `retire`=1.
  - `illegal` is tied to 0.
  - The HALT state is not compiled in.

## Structure
- Shared package `cpu_pkg` holds:
  - Opcode constants.
  - ALU op constants.
  - `pc_src` and `alu_src_b` encodings.
  - The `mc_state_t` enum.
- One natural sub-module, `multicycle_ctrl_decode`: purely combinational map from (state, opcode, zero, `mem_ready`) to the output bundle. The top keeps the state register, next-state logic and wait counter.

## Test plan
- Reset release with `mem_ready`=1, opcode ADD:
  - IDLE, FETCH, DECODE, EXEC_R, WB_R.
  - `reg_write`=1, `reg_dst`=1 in the 5th cycle; `retire` high in that cycle only.
- LW with `mem_ready` held low 3 cycles in MEM_RD:
  - `mem_read`=1, `iord`=1 for 4 cycles.
  - WB_MEM with `mem_to_reg`=1; total 8 cycles.
- BEQ, `zero`=1: BRANCH asserts `pc_write`=1, `pc_src`=1.
- BNE, `zero`=1: `pc_write`=0; both take 3 cycles.
- Opcode 0x3F:
  - With TRAP_EN: HALT and `illegal`=1 forever until `rst_n`=0.
  - Without: 2-cycle NOP with one `retire` pulse.
- `mem_ready`=0 for 20 cycles in FETCH with `MEM_WAIT_MAX`=15: `mem_timeout` rises on the 16th waiting cycle, and the FSM stays in FETCH.
- `rst_n` pulsed low during MEM_WR: `mem_write` drops immediately; state IDLE; no `retire`.
